// File: rtl/sipo_align.sv
// sipo_align: serial-to-parallel deserializer with sync-word alignment.
// Bits arrive on i_rxp at the recovered serial clock sclk. A free-running
// divider marks word boundaries and produces a 50% duty parallel clock.
// In SEARCH, the word phase snaps to wherever SYNC_WORD is seen; VERIFY
// then confirms LOCK_COUNT consecutive sync words before LOCKED is reported.
module sipo_align #(
  parameter int                PWIDTH     = 20,
  parameter logic [PWIDTH-1:0] SYNC_WORD  = 20'h0F83E,
  parameter int                LOCK_COUNT = 4,
  parameter bit                MSB_FIRST  = 1'b1,
  parameter int                CNTW       = 8
) (
  input  logic              sclk,
  input  logic              i_rst,
  input  logic              i_slock,
  input  logic              i_realign,
  input  logic              i_rxp,
  output logic              o_pclk,
  output logic [PWIDTH-1:0] o_pdata,
  output logic              o_pvalid,
  output logic              o_plock,
  output logic [CNTW-1:0]   o_realign_cnt
);

  localparam int DW = $clog2(PWIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(PWIDTH - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(PWIDTH / 2);
  localparam logic [3:0]    LOCK_CNT = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PWIDTH-1:0]   sr_q, sr_d;
  logic [DW-1:0]       divp_q, divp_d;
  logic [3:0]          vcnt_q, vcnt_d;
  logic [PWIDTH-1:0]   pdata_q, pdata_d;
  logic                pvalid_q, pvalid_d;
  logic                pclk_q, pclk_d;
  logic                plock_q, plock_d;
  logic [CNTW-1:0]     rcnt_q, rcnt_d;

  logic                capture;
  logic                sync_hit;
  logic                realign_req;
  logic [CNTW-1:0]     rcnt_inc;

  assign capture     = (divp_q == DIV_LAST);
  assign sync_hit    = (sr_q == SYNC_WORD);
  assign realign_req = !i_slock || i_realign;
  // Loss counter sticks at all-ones rather than wrapping.
  assign rcnt_inc    = (rcnt_q == {CNTW{1'b1}}) ? rcnt_q : rcnt_q + 1'b1;

  // Shift register input: bit order selects which end the new bit enters.
  always_comb begin
    if (MSB_FIRST) begin
      sr_d = {sr_q[PWIDTH-2:0], i_rxp};
    end else begin
      sr_d = {i_rxp, sr_q[PWIDTH-1:1]};
    end
  end

  // Next-state: divider, word capture, alignment FSM, loss counter, pclk.
  always_comb begin
    state_d  = state_q;
    vcnt_d   = vcnt_q;
    plock_d  = plock_q;
    rcnt_d   = rcnt_q;
    pdata_d  = pdata_q;
    pvalid_d = 1'b0;
    divp_d   = capture ? '0 : divp_q + 1'b1;

    // Word capture runs in every state so the consumer always sees words.
    if (capture) begin
      pdata_d  = sr_q;
      pvalid_d = 1'b1;
    end

    case (state_q)
      S_SEARCH: begin
        plock_d = 1'b0;
        // A sync hit re-phases the divider so this edge becomes a boundary.
        if (!realign_req && sync_hit) begin
          divp_d   = '0;
          pdata_d  = sr_q;
          pvalid_d = 1'b1;
          vcnt_d   = 4'd1;
          if (LOCK_COUNT == 1) begin
            state_d = S_LOCKED;
            plock_d = 1'b1;
          end else begin
            state_d = S_VERIFY;
          end
        end
      end
      S_VERIFY: begin
        if (realign_req) begin
          state_d = S_SEARCH;
          plock_d = 1'b0;
          vcnt_d  = 4'd0;
          rcnt_d  = rcnt_inc;
        end else if (capture) begin
          if (sync_hit) begin
            vcnt_d = vcnt_q + 4'd1;
            if (vcnt_q + 4'd1 == LOCK_CNT) begin
              state_d = S_LOCKED;
              plock_d = 1'b1;
            end
          end else begin
            state_d = S_SEARCH;
            vcnt_d  = 4'd0;
            rcnt_d  = rcnt_inc;
          end
        end
      end
      S_LOCKED: begin
        if (realign_req) begin
          state_d = S_SEARCH;
          plock_d = 1'b0;
          vcnt_d  = 4'd0;
          rcnt_d  = rcnt_inc;
        end else begin
          plock_d = 1'b1;
        end
      end
      default: begin
        state_d = S_SEARCH;
        plock_d = 1'b0;
        vcnt_d  = 4'd0;
      end
    endcase

    // pclk follows the divider value being loaded, so a forced re-phase
    // also pulls pclk low at the new word boundary.
    pclk_d = pclk_q;
    if (divp_d == '0) begin
      pclk_d = 1'b0;
    end else if (divp_d == DIV_HALF) begin
      pclk_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge sclk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_SEARCH;
      sr_q     <= '0;
      divp_q   <= '0;
      vcnt_q   <= 4'd0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
      pclk_q   <= 1'b0;
      plock_q  <= 1'b0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      divp_q   <= divp_d;
      vcnt_q   <= vcnt_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
      pclk_q   <= pclk_d;
      plock_q  <= plock_d;
      rcnt_q   <= rcnt_d;
    end
  end

  assign o_pclk        = pclk_q;
  assign o_pdata       = pdata_q;
  assign o_pvalid      = pvalid_q;
  assign o_plock       = plock_q;
  assign o_realign_cnt = rcnt_q;

endmodule

// File: tb/tb_sipo_align.sv
// Directed bench for sipo_align. Two instances share clock, reset and
// control: dut (MSB first, 8-bit loss counter) and dut2 (LSB first, 2-bit
// loss counter) receive the same words, each in its own bit order.
module tb_sipo_align;

  localparam logic [19:0] SYNC = 20'h0F83E;

  logic        sclk = 1'b0;
  logic        i_rst, i_slock, i_realign;
  logic        rxp, rxp2;

  logic        o_pclk, o_pvalid, o_plock;
  logic [19:0] o_pdata;
  logic [7:0]  o_cnt;
  logic        o_pclk2, o_pvalid2, o_plock2;
  logic [19:0] o_pdata2;
  logic [1:0]  o_cnt2;

  int n_vec = 0;
  int n_bad = 0;

  int          tick_no;
  int          pclk_tog;
  int          first_rise;
  int          rise_tick;
  logic        pclk_prev, plock_prev;
  logic [19:0] pv_q[$];
  int          pt_q[$];
  logic [19:0] pv2_q[$];

  always #5 sclk = ~sclk;

  sipo_align dut (
    .sclk(sclk), .i_rst(i_rst), .i_slock(i_slock), .i_realign(i_realign),
    .i_rxp(rxp), .o_pclk(o_pclk), .o_pdata(o_pdata), .o_pvalid(o_pvalid),
    .o_plock(o_plock), .o_realign_cnt(o_cnt)
  );

  sipo_align #(.MSB_FIRST(1'b0), .CNTW(2)) dut2 (
    .sclk(sclk), .i_rst(i_rst), .i_slock(i_slock), .i_realign(i_realign),
    .i_rxp(rxp2), .o_pclk(o_pclk2), .o_pdata(o_pdata2), .o_pvalid(o_pvalid2),
    .o_plock(o_plock2), .o_realign_cnt(o_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic clear_mon();
    tick_no    = 0;
    pclk_tog   = 0;
    first_rise = 0;
    rise_tick  = 0;
    pclk_prev  = o_pclk;
    plock_prev = o_plock;
    pv_q.delete();
    pt_q.delete();
    pv2_q.delete();
  endtask

  // One sclk edge; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge sclk);
    #1;
    tick_no++;
    if (o_pvalid) begin
      pv_q.push_back(o_pdata);
      pt_q.push_back(tick_no);
    end
    if (o_pvalid2) pv2_q.push_back(o_pdata2);
    if (o_pclk != pclk_prev) pclk_tog++;
    if (o_pclk && !pclk_prev && first_rise == 0) first_rise = tick_no;
    pclk_prev = o_pclk;
    if (o_plock && !plock_prev) rise_tick = tick_no;
    plock_prev = o_plock;
  endtask

  task automatic send_bit(input logic b1, input logic b2);
    rxp  = b1;
    rxp2 = b2;
    tick();
  endtask

  task automatic send_word(input logic [19:0] w);
    for (int i = 0; i < 20; i++) begin
      rxp  = w[19-i];
      rxp2 = w[i];
      tick();
    end
  endtask

  initial begin
    i_rst = 1'b1; i_slock = 1'b1; i_realign = 1'b0; rxp = 1'b0; rxp2 = 1'b0;
    tick_no = 0; pclk_tog = 0; first_rise = 0; rise_tick = 0;
    pclk_prev = 1'b0; plock_prev = 1'b0;
    tick();
    tick();
    chk("rst_pdata",  32'(o_pdata), 0);
    chk("rst_pvalid", 32'(o_pvalid), 0);
    chk("rst_pclk",   32'(o_pclk), 0);
    chk("rst_plock",  32'(o_plock), 0);
    chk("rst_cnt",    32'(o_cnt), 0);
    chk("rst_cnt2",   32'(o_cnt2), 0);

    // Idle traffic that can never contain the sync word.
    i_rst = 1'b0;
    clear_mon();
    for (int i = 0; i < 200; i++) send_bit(i % 3 == 0, i % 3 == 0);
    chk("idle_pvalid_n",     32'(pt_q.size()), 10);
    chk("idle_pvalid_first", 32'(pt_q[0]), 20);
    chk("idle_pvalid_gap",   32'(pt_q[1] - pt_q[0]), 20);
    chk("idle_pclk_toggles", 32'(pclk_tog), 20);
    chk("idle_pclk_rise",    32'(first_rise), 10);
    chk("idle_plock",        32'(o_plock), 0);
    chk("idle_cnt",          32'(o_cnt), 0);
    chk("idle_pvalid_n2",    32'(pv2_q.size()), 10);

    // Offset alignment: 7 junk bits, 4 sync words, two payload words.
    clear_mon();
    repeat (7) send_bit(1'b0, 1'b0);
    repeat (4) send_word(SYNC);
    send_word(20'h12345);
    send_word(20'hABCDE);
    send_word(20'h00000);
    chk("aln_nwords",   32'(pv_q.size()), 7);
    chk("aln_sync1",    32'(pv_q[1]), 32'(SYNC));
    chk("aln_sync1_t",  32'(pt_q[1]), 28);
    chk("aln_sync4",    32'(pv_q[4]), 32'(SYNC));
    chk("aln_lock_t",   32'(rise_tick), 88);
    chk("aln_w0",       32'(pv_q[5]), 32'h12345);
    chk("aln_w0_t",     32'(pt_q[5]), 108);
    chk("aln_w1",       32'(pv_q[6]), 32'hABCDE);
    chk("aln_w1_t",     32'(pt_q[6]), 128);
    chk("aln_plock",    32'(o_plock), 1);
    chk("aln_lsb_w0",   32'(pv2_q[pv2_q.size()-2]), 32'h12345);
    chk("aln_lsb_w1",   32'(pv2_q[pv2_q.size()-1]), 32'hABCDE);
    chk("aln_lsb_lock", 32'(o_plock2), 1);

    // Lock loss: slock low for 3 sclk counts one loss.
    i_slock = 1'b0;
    send_bit(1'b0, 1'b0);
    chk("loss_plock", 32'(o_plock), 0);
    chk("loss_cnt",   32'(o_cnt), 1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    i_slock = 1'b1;
    chk("loss_cnt_hold", 32'(o_cnt), 1);

    // Verify failure: two syncs then a bad word.
    clear_mon();
    send_word(SYNC);
    send_word(SYNC);
    send_word(20'h00000);
    send_bit(1'b0, 1'b0);
    chk("vfail_cnt",       32'(o_cnt), 2);
    chk("vfail_cnt2",      32'(o_cnt2), 2);
    chk("vfail_no_lock",   32'(rise_tick), 0);

    // Relock with four sync words.
    repeat (4) send_word(SYNC);
    send_bit(1'b0, 1'b0);
    chk("relock_plock",  32'(o_plock), 1);
    chk("relock_plock2", 32'(o_plock2), 1);

    // Held realign counts once; then more losses to saturate dut2.
    i_realign = 1'b1;
    repeat (3) send_bit(1'b0, 1'b0);
    i_realign = 1'b0;
    chk("rea_hold_cnt",   32'(o_cnt), 3);
    chk("rea_hold_plock", 32'(o_plock), 0);
    repeat (2) begin
      send_word(SYNC);
      send_bit(1'b0, 1'b0);
      i_realign = 1'b1;
      send_bit(1'b0, 1'b0);
      i_realign = 1'b0;
    end
    chk("sat_cnt",  32'(o_cnt), 5);
    chk("sat_cnt2", 32'(o_cnt2), 3);

    // Reset while locked, mid-word.
    repeat (4) send_word(SYNC);
    send_bit(1'b0, 1'b0);
    chk("prerst_plock", 32'(o_plock), 1);
    repeat (12) send_bit(1'b1, 1'b1);
    chk("prerst_pclk",  32'(o_pclk), 1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_pdata",  32'(o_pdata), 0);
    chk("arst_pclk",   32'(o_pclk), 0);
    chk("arst_plock",  32'(o_plock), 0);
    chk("arst_cnt",    32'(o_cnt), 0);
    chk("arst_cnt2",   32'(o_cnt2), 0);
    chk("arst_pdata2", 32'(o_pdata2), 0);
    tick();
    i_rst = 1'b0;
    clear_mon();
    repeat (3) send_word(SYNC);
    chk("post_rst_vfy_plock", 32'(o_plock), 0);
    send_word(SYNC);
    send_bit(1'b0, 1'b0);
    chk("post_rst_plock", 32'(o_plock), 1);
    chk("post_rst_cnt",   32'(o_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
